wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter REG_ADDRESS_LEN, default 4, register address width.
REQ-002 SHALL have parameter REGISTER_LEN, default 32, data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, maximum consecutive denials of requester B.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports a_valid, a_dest, a_data (input, 1/REG_ADDRESS_LEN/REGISTER_LEN): pipeline write-back request A, no handshake.
REQ-007 SHALL have ports b_valid, b_dest, b_data (input, 1/REG_ADDRESS_LEN/REGISTER_LEN) and b_ready (output, 1): multi-cycle unit request B, valid/ready handshake.
REQ-008 SHALL have output stall_a, 1: requester A SHALL hold a_valid low while stall_a is high.
REQ-009 SHALL have inputs rsv_valid (1) and rsv_dest (REG_ADDRESS_LEN), plus output rsv_ready (1): destination reservation for B.
REQ-010 SHALL have inputs src1, src2 (REG_ADDRESS_LEN), use_src1, use_src2 (1), plus output hazard (1).
REQ-011 SHALL have outputs writeBackEn (1), Dest_wb (REG_ADDRESS_LEN), Result_wb (REGISTER_LEN), which drive the register file write port.

Function
REQ-012 SHALL use grant priority stall_a-forced B > A > B; at most one grant per cycle.
REQ-013 SHALL compute b_ready combinationally as b_valid & (stall_a | ~a_valid); a B transfer occurs when b_valid & b_ready.
REQ-014 SHALL register the winner's dest/data into Dest_wb/Result_wb with writeBackEn=1 on the grant edge; latency 1 cycle; writeBackEn=0 in a cycle with no grant.
REQ-015 SHALL keep starve_cnt (width clog2(STARVE_LIMIT+1)): increment when b_valid & ~b_ready, clear on B transfer or ~b_valid, saturate at STARVE_LIMIT.
REQ-016 SHALL register stall_a high in the cycle after starve_cnt reaches STARVE_LIMIT-1 and is incremented, hold it for exactly one cycle, then deassert it; starve_cnt SHALL clear when stall_a is high.
REQ-017 SHALL hold a busy bitmap of 2^REG_ADDRESS_LEN bits; a reservation occurs when rsv_valid & rsv_ready and sets busy[rsv_dest] on the clock edge.
REQ-018 SHALL set rsv_ready = ~busy[rsv_dest] combinationally, allowing one outstanding reservation per register.
REQ-019 SHALL clear busy[b_dest] on the clock edge of a B transfer.
REQ-020 SHALL leave busy[rsv_dest]=1 when a same-edge B-transfer clear and new reservation target the same register (set wins).
REQ-021 SHALL leave busy unchanged on A writes, including A writes to a busy register.
REQ-022 SHALL compute hazard = (use_src1 & busy[src1]) | (use_src2 & busy[src2]) combinationally from current state, excluding the current-cycle clear.
REQ-023 SHALL treat a_valid while stall_a=1 as a protocol violation: the A request SHALL be dropped and B granted.

Reset
REQ-024 SHALL, on rst low at any time including mid-transfer, asynchronously force writeBackEn=0, Dest_wb=0, Result_wb=0, stall_a=0, busy=all zeros, and starve_cnt=0.
REQ-025 SHALL cause an in-flight B request to be re-presented after reset; no grant is remembered.
REQ-026 SHALL produce its first grant on the first rising edge after rst returns high.

Verification
REQ-027 A alone: a_valid=1, a_dest=3, a_data=0x55 -> next cycle writeBackEn=1, Dest_wb=3, Result_wb=0x55.
REQ-028 Collision: a_valid and b_valid both 1 -> b_ready=0, A written; a_valid drops -> B written one cycle later.
REQ-029 Starvation (STARVE_LIMIT=4): a_valid=1 continuously with b_valid=1 -> after 4 denials stall_a=1 for one cycle, B written with b_dest/b_data, starve_cnt returns to 0.
REQ-030 Scoreboard: reserve r5, then src1=5 with use_src1=1 -> hazard=1 and rsv_ready=0 for r5; B transfer with b_dest=5 -> hazard=0 on the next cycle.
REQ-031 Same-edge: B transfer clearing r7 together with a reservation of r7 -> busy[7]=1 after the edge.
REQ-032 Reset mid-operation: pull rst low with busy=0x00F0 and stall_a=1 -> all outputs 0 and busy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: arbitrates register-file write-back between pipeline port A and handshaked port B,
// with a starvation guard for B and a per-register busy scoreboard for B reservations.
module wb_port_arbiter #(
  parameter int REG_ADDRESS_LEN = 4,
  parameter int REGISTER_LEN    = 32,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  input  logic [REG_ADDRESS_LEN-1:0] a_dest,
  input  logic [REGISTER_LEN-1:0]    a_data,
  input  logic                       b_valid,
  input  logic [REG_ADDRESS_LEN-1:0] b_dest,
  input  logic [REGISTER_LEN-1:0]    b_data,
  output logic                       b_ready,
  output logic                       stall_a,
  input  logic                       rsv_valid,
  input  logic [REG_ADDRESS_LEN-1:0] rsv_dest,
  output logic                       rsv_ready,
  input  logic [REG_ADDRESS_LEN-1:0] src1,
  input  logic [REG_ADDRESS_LEN-1:0] src2,
  input  logic                       use_src1,
  input  logic                       use_src2,
  output logic                       hazard,
  output logic                       writeBackEn,
  output logic [REG_ADDRESS_LEN-1:0] Dest_wb,
  output logic [REGISTER_LEN-1:0]    Result_wb
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam int NR = 2 ** REG_ADDRESS_LEN;

  logic [CW-1:0]              starve_cnt_q, starve_cnt_d;
  logic                       stall_a_q, stall_a_d, wb_en_q, wb_en_d;
  logic [REG_ADDRESS_LEN-1:0] dest_q, dest_d;
  logic [REGISTER_LEN-1:0]    result_q, result_d;
  logic [NR-1:0]              busy_q, busy_d;
  logic                       b_xfer, a_grant, b_denied;

  // A is only granted when not force-stalled; a_valid during stall is dropped
  assign b_ready   = b_valid & (stall_a_q | ~a_valid);
  assign b_xfer    = b_valid & b_ready;
  assign b_denied  = b_valid & ~b_ready;
  assign a_grant   = a_valid & ~stall_a_q;
  assign rsv_ready = ~busy_q[rsv_dest];
  assign hazard    = (use_src1 & busy_q[src1]) | (use_src2 & busy_q[src2]);

  assign stall_a     = stall_a_q;
  assign writeBackEn = wb_en_q;
  assign Dest_wb     = dest_q;
  assign Result_wb   = result_q;

  always_comb begin
    wb_en_d      = a_grant | b_xfer;
    dest_d       = b_xfer ? b_dest : a_grant ? a_dest : dest_q;
    result_d     = b_xfer ? b_data : a_grant ? a_data : result_q;
    stall_a_d    = b_denied & (starve_cnt_q == CW'(STARVE_LIMIT - 1));
    starve_cnt_d = (stall_a_q | ~b_valid | b_xfer) ? '0 :
                   (starve_cnt_q == CW'(STARVE_LIMIT)) ? starve_cnt_q : starve_cnt_q + 1'b1;
    busy_d       = busy_q;
    if (b_xfer) busy_d[b_dest] = 1'b0;
    if (rsv_valid & rsv_ready) busy_d[rsv_dest] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
      stall_a_q    <= 1'b0;
      wb_en_q      <= 1'b0;
      dest_q       <= '0;
      result_q     <= '0;
      busy_q       <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      stall_a_q    <= stall_a_d;
      wb_en_q      <= wb_en_d;
      dest_q       <= dest_d;
      result_q     <= result_d;
      busy_q       <= busy_d;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: vector table plus hand sequences; write-back results checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_wb_port_arbiter;
  logic        clk = 0, rst = 1;
  logic        a_valid = 0, b_valid = 0, rsv_valid = 0, use_src1 = 0, use_src2 = 0;
  logic [3:0]  a_dest = 0, b_dest = 0, rsv_dest = 0, src1 = 0, src2 = 0;
  logic [31:0] a_data = 0, b_data = 0;
  logic        b_ready, stall_a, rsv_ready, hazard, writeBackEn;
  logic [3:0]  Dest_wb;
  logic [31:0] Result_wb;
  int          checks = 0, errors = 0;

  typedef struct {
    logic av; logic [3:0] ad; logic [31:0] adat;
    logic bv; logic [3:0] bd; logic [31:0] bdat;
    logic rv; logic [3:0] rd;
    logic [3:0] s1; logic u1; logic [3:0] s2; logic u2;
    logic br, st, rr, hz, en; logic [3:0] d; logic [31:0] r;
  } vec_t;
  typedef struct { logic en; logic [3:0] d; logic [31:0] r; } exp_t;

  vec_t vt[15];
  exp_t sb[$];

  wb_port_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data),
    .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ready(b_ready),
    .stall_a(stall_a),
    .rsv_valid(rsv_valid), .rsv_dest(rsv_dest), .rsv_ready(rsv_ready),
    .src1(src1), .src2(src2), .use_src1(use_src1), .use_src2(use_src2), .hazard(hazard),
    .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .Result_wb(Result_wb)
  );

  always #10 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [3:0] ad, input logic [31:0] adat,
                              input logic bv, input logic [3:0] bd, input logic [31:0] bdat,
                              input logic br, input logic st, input logic en,
                              input logic [3:0] d, input logic [31:0] r);
    mk = '{av, ad, adat, bv, bd, bdat, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, br, st, 1'b1, 1'b0, en, d, r};
  endfunction

  task automatic step(input vec_t v, input string n);
    exp_t e;
    a_valid = v.av; a_dest = v.ad; a_data = v.adat;
    b_valid = v.bv; b_dest = v.bd; b_data = v.bdat;
    rsv_valid = v.rv; rsv_dest = v.rd;
    src1 = v.s1; use_src1 = v.u1; src2 = v.s2; use_src2 = v.u2;
    #1;
    chk({n, " b_ready"}, b_ready, v.br);
    chk({n, " stall_a"}, stall_a, v.st);
    chk({n, " rsv_ready"}, rsv_ready, v.rr);
    chk({n, " hazard"}, hazard, v.hz);
    sb.push_back('{v.en, v.d, v.r});
    @(posedge clk); #1;
    if (sb.size() == 0) chk({n, " scoreboard empty"}, 1, 0);
    else begin
      e = sb.pop_front();
      chk({n, " writeBackEn"}, writeBackEn, e.en);
      if (e.en) begin
        chk({n, " Dest_wb"}, Dest_wb, e.d);
        chk({n, " Result_wb"}, Result_wb, e.r);
      end
    end
  endtask

  task automatic sweep(input logic [15:0] busy, input string n);
    use_src2 = 0; use_src1 = 1; rsv_valid = 0;
    for (int i = 0; i < 16; i++) begin
      rsv_dest = 4'(i); src1 = 4'(i);
      #0.5;
      chk($sformatf("%s rsv_ready r%0d", n, i), rsv_ready, !busy[i]);
      chk($sformatf("%s hazard r%0d", n, i), hazard, busy[i]);
    end
  endtask

  initial begin
    //          av ad adat    bv bd bdat      rv rd s1 u1 s2 u2  br st rr hz en d  r
    vt[0]  = '{0, 0, 0,      0, 0, 0,        0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0};
    vt[1]  = '{1, 3, 'h55,   0, 0, 0,        0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 3, 'h55};
    vt[2]  = '{1, 1, 'h11,   1, 2, 'h22,     0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 1, 'h11};
    vt[3]  = '{0, 0, 0,      1, 2, 'h22,     0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 1, 2, 'h22};
    vt[4]  = '{0, 0, 0,      0, 0, 0,        1, 5, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0};
    vt[5]  = '{0, 0, 0,      0, 0, 0,        0, 5, 5, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0};
    vt[6]  = '{0, 0, 0,      1, 5, 'h5a5a,   0, 5, 5, 1, 0, 0,  1, 0, 0, 1, 1, 5, 'h5a5a};
    vt[7]  = '{0, 0, 0,      0, 0, 0,        0, 5, 5, 1, 0, 0,  0, 0, 1, 0, 0, 0, 0};
    vt[8]  = '{0, 0, 0,      0, 0, 0,        1, 9, 0, 0, 9, 1,  0, 0, 1, 0, 0, 0, 0};
    vt[9]  = '{0, 0, 0,      0, 0, 0,        0, 9, 5, 1, 9, 1,  0, 0, 0, 1, 0, 0, 0};
    vt[10] = '{0, 0, 0,      0, 0, 0,        0, 9, 3, 1, 9, 0,  0, 0, 0, 0, 0, 0, 0};
    vt[11] = '{0, 0, 0,      1, 7, 'h77,     1, 7, 0, 0, 0, 0,  1, 0, 1, 0, 1, 7, 'h77};
    vt[12] = '{0, 0, 0,      0, 0, 0,        0, 7, 7, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0};
    vt[13] = '{1, 9, 'h99,   0, 0, 0,        0, 0, 0, 0, 9, 1,  0, 0, 1, 1, 1, 9, 'h99};
    vt[14] = '{0, 0, 0,      0, 0, 0,        0, 9, 0, 0, 9, 1,  0, 0, 0, 1, 0, 0, 0};

    #1 rst = 0;
    #2;
    chk("reset writeBackEn", writeBackEn, 0);
    chk("reset Dest_wb", Dest_wb, 0);
    chk("reset Result_wb", Result_wb, 0);
    chk("reset stall_a", stall_a, 0);
    chk("reset rsv_ready", rsv_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1;

    for (int i = 0; i < 15; i++) step(vt[i], $sformatf("v%0d", i));

    // starvation: stall after 4 denials, counter restarts, violating a_valid dropped on 2nd stall
    for (int k = 0; k < 10; k++) begin
      logic s;
      s = (k == 4 || k == 9);
      step(mk(k != 4, 4, 'hA0 + k, 1, 'hC, 'hCC, s, s, 1, s ? 4'hC : 4'd4, s ? 32'hCC : 32'hA0 + k),
           $sformatf("starve%0d", k));
    end
    // a gap in b_valid clears the denial count
    for (int k = 0; k < 7; k++)
      step(mk(1, 4, 'hB0 + k, k != 3, 'hC, 'hCC, 0, 0, 1, 4, 'hB0 + k), $sformatf("gap%0d", k));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "gap_idle");

    rst = 0; #2 rst = 1;
    for (int i = 4; i < 8; i++)
      step('{0, 0, 0, 0, 0, 0, 1, 4'(i), 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0}, $sformatf("rsv%0d", i));
    for (int k = 0; k < 4; k++)
      step(mk(1, 1, 'h10 + k, 1, 3, 'hBB, 0, 0, 1, 1, 'h10 + k), $sformatf("deny%0d", k));
    chk("pre-reset stall_a", stall_a, 1);
    sweep(16'h00F0, "pre-reset");
    rst = 0;
    #1;
    chk("mid reset stall_a", stall_a, 0);
    chk("mid reset writeBackEn", writeBackEn, 0);
    chk("mid reset Dest_wb", Dest_wb, 0);
    chk("mid reset Result_wb", Result_wb, 0);
    chk("mid reset b_ready", b_ready, 0);
    sweep(16'h0000, "mid-reset");
    rst = 1;
    step(mk(0, 0, 0, 1, 3, 'hBB, 1, 0, 1, 3, 'hBB), "post-reset B");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post-reset idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
